// File: rtl/serial_sub_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns status and result.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Computes (a - b) mod 2^WIDTH in WIDTH cycles; diff/borrow_out hold until next completion.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  serial_sub_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [WIDTH-1:0] res, res_n;
  logic [WIDTH-1:0] diff_q, diff_n;
  logic             bw, bw_n;
  logic             bo_q, bo_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ai, bi, d;
  logic             last_bit;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      diff_q <= '0;
      bw     <= 1'b0;
      bo_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      sa     <= sa_n;
      sb     <= sb_n;
      res    <= res_n;
      diff_q <= diff_n;
      bw     <= bw_n;
      bo_q   <= bo_n;
      busy_q <= busy_n;
      done_q <= done_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state, full-subtractor cell and registered-output decode
  always_comb begin
    state_n  = state;
    sa_n     = sa;
    sb_n     = sb;
    res_n    = res;
    diff_n   = diff_q;
    bw_n     = bw;
    bo_n     = bo_q;
    cnt_n    = cnt;
    ai       = sa[0];
    bi       = sb[0];
    d        = ai ^ bi ^ bw;
    last_bit = (cnt == CW'(WIDTH - 1));

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_RUN;
          sa_n    = bus.a;
          sb_n    = bus.b;
          bw_n    = 1'b0;
          cnt_n   = '0;
          res_n   = '0;
        end
      end
      S_RUN: begin
        bw_n  = (~ai & bi) | (~(ai ^ bi) & bw);
        sa_n  = sa >> 1;
        sb_n  = sb >> 1;
        res_n = {d, res[WIDTH-1:1]};
        if (last_bit) begin
          // Hold the counter on the final bit so it never wraps
          state_n = S_DONE;
          diff_n  = {d, res[WIDTH-1:1]};
          bo_n    = (~ai & bi) | (~(ai ^ bi) & bw);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n == S_RUN);
    done_n = (state_n == S_DONE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;

endmodule
